dmem_arbiter: RTL

- Shares the single-port 256x8 data memory (ports A, WD, mem_write, read data out) between NUM_REQ requesters, e.g. the CPU load/store unit and a DMA/debug port.
- Each requester uses a valid/ready request channel and gets a one-cycle response pulse.
- Round-robin arbitration gives every requester a starvation-free share of the memory.
- One memory access is in flight at a time, sequenced by a small FSM.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_arbiter.sv | 32 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_REQ_DEF = 2;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int MEM_DEPTH   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first valid requester after last_grant wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read 256x8 memory port between
// several valid/ready requesters, one access in flight at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         A,
    output logic [DATA_W-1:0]         WD,
    output logic                      mem_write,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t state, state_next;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   lat_id;
    logic               any_req;
    logic               handshake;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDX_W-1:0] id);
        id_onehot     = '0;
        id_onehot[id] = 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .found      (any_req)
    );

    // Ready is offered only while idle; gated by reset so it reads zero during reset.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;
    assign handshake = (state == IDLE) && any_req;
    assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    assign mem_write = (state == WRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = req_write[grant_idx] ? WRITE : READ;
            WRITE:   state_next = IDLE;
            READ:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A doubles as the latched address; WD only moves on a write grant so it
    // keeps its last driven value across reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            lat_id     <= '0;
            A          <= '0;
            WD         <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= '0;
            if (handshake) begin
                last_grant <= grant_idx;
                lat_id     <= grant_idx;
                A          <= sel_addr;
                if (req_write[grant_idx]) begin
                    WD <= sel_wdata;
                end
            end
            if (state == WRITE) begin
                rsp_valid <= id_onehot(lat_id);
            end
            if (state == RESP) begin
                rsp_valid <= id_onehot(lat_id);
                rsp_rdata <= mem_rdata;
            end
        end
    end

endmodule
